uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first, idle-high line; the receiving end for `uart_tx` frames. It sits between the asynchronous `rxSerial` pin and the byte-level consumer logic. Baud timing comes from a runtime `clocksPerBit` value, computed as int(clock/baudRate), for example 5208 at 50 MHz / 9600 baud. Each received byte produces a one-cycle `rxDv` pulse, and malformed frames are flagged.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the input synchronizer (≥2).
- `clk`  in  1: system clock, rising edge.
- `rstN`  in  1: asynchronous, active-low reset.
- `rxSerial`  in  1: asynchronous serial line, idle high.
- `clocksPerBit`  in  32: clk cycles per bit. Values below 4 are clamped to 4. Latched at start-bit detection.
- `rxDv`  out  1: one-cycle pulse when `rxByte` holds a newly received, valid byte.
- `rxByte`  out  8: last valid received byte. Held until the next valid frame.
- `rxActive`  out  1: high while a frame is in progress (START, DATA and STOP states).
- `rxFrameError`  out  1: one-cycle pulse when the stop bit is sampled low.

## Operation
- `rxSerial` passes through a `SYNC_STAGES` synchronizer, giving `rxSync`. The synchronizer flops reset to 1.
- Let N be the latched, clamped `clocksPerBit` and H = N>>1.
- One counter (32-bit) and a bit index (3-bit) drive the FSM. States:
  - IDLE: when `rxSync`==0, latch N, clear the counter, go to START.
  - START: at counter==H-1, sample `rxSync`. If 0, clear the counter, set bit index to 0 and go to DATA. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: at counter==N-1, shift `rxSync` into the shift register at bit[index] (LSB first) and clear the counter. After index 7, go to STOP. Otherwise increment the index.
  - STOP: at counter==N-1, sample `rxSync`.
    - If 1: copy the shift register to `rxByte`, pulse `rxDv`, go to IDLE.
    - If 0: pulse `rxFrameError`, leave `rxByte` unchanged, go to BREAK.
  - BREAK: wait for `rxSync`==1, then go to IDLE. No start detection happens in this state.
- Sampling points are mid-bit. Returning to IDLE at mid-stop-bit allows back-to-back frames with a single stop bit.
- A change to `clocksPerBit` mid-frame has no effect until the next start detection.
- Reset at any time (mid-frame included):
  - FSM goes to IDLE; counter and index are cleared.
  - `rxByte`=0, `rxDv`=0, `rxFrameError`=0, `rxActive`=0.
  - Any partial frame is discarded.

## Timing
- Reset values: `rxDv`=0, `rxByte`=8'h00, `rxActive`=0, `rxFrameError`=0.
- All outputs are registered.
- Let T0 be the clk edge at which IDLE sees `rxSync`==0. This is `SYNC_STAGES` to `SYNC_STAGES`+1 cycles after the pin's falling edge.
- Sample points, relative to T0:
  - Start bit: T0+H.
  - Data bit i: T0+H+(i+1)·N.
  - Stop bit: T0+H+9N.
- `rxDv` / `rxFrameError` are high for exactly the one cycle after the stop sample edge. `rxByte` updates on that same edge.
- `rxActive` rises at T0+1 and falls together with the `rxDv` / `rxFrameError` pulse. In BREAK it is 0.
- Input latency from pin to `rxDv` is about 9.5 bit periods plus `SYNC_STAGES`+1 cycles.
- A start edge arriving on the cycle right after the stop sample is accepted. There is no dead time beyond one cycle.

## Structure
- Shared package `uart_pkg` holds:
  - The FSM state enum typedef (IDLE, START, DATA, STOP, BREAK).
  - `UART_DATA_BITS`=8.
  - `UART_MIN_CLOCKS_PER_BIT`=4.
- Sub-module `uart_sync`: a parameterized N-flop synchronizer with reset value 1. It is reusable by `uart_tx`-side control inputs.
- `uart_receiver` contains the FSM, counter, shift register and output registers.

## Test plan
- Single byte: `clocksPerBit`=16, drive 8'hA5 as 8N1 → one `rxDv` pulse with `rxByte`=8'hA5, `rxFrameError` never high, `rxActive` high for about 9.5·16 cycles.
- Back-to-back loopback at 50 MHz / 9600 (`clocksPerBit`=5208): `uart_tx` sends 8'h07, 8'h00, 8'hFF with one stop bit each → three `rxDv` pulses carrying 8'h07, 8'h00, 8'hFF, in order.
- Glitch rejection: `clocksPerBit`=16, low pulse of 5 cycles on `rxSerial` → no `rxDv`, no error, FSM returns to IDLE, `rxActive` drops within H+2 cycles.
- Framing error / break: `clocksPerBit`=16, frame 8'h3C with stop bit low, line then held low for 40 cycles → `rxFrameError` pulses once, `rxByte` keeps its previous value, no new frame starts until the line goes high. A following valid 8'h11 is then received correctly.
- Reset mid-frame: deassert `rstN` after bit 3 of 8'hC3 → all outputs return to 0 immediately. After release, the next full frame 8'h5A gives `rxByte`=8'h5A with no stale bits.
- Clamp and latch: `clocksPerBit`=1 with a frame driven at 4 cycles/bit gives a correct byte. Changing `clocksPerBit` from 16 to 32 mid-frame does not corrupt the current frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the FSM state encoding and the baud clamp helper.
package uart_pkg;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_MIN_CLOCKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    function automatic logic [31:0] clamp_cpb(input logic [31:0] cpb);
        if (cpb < 32'(UART_MIN_CLOCKS_PER_BIT))
            return 32'(UART_MIN_CLOCKS_PER_BIT);
        return cpb;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-level output bundle of the UART receiver.
// The master drives the decoded byte and status strobes.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                      rxDv;
    logic [UART_DATA_BITS-1:0] rxByte;
    logic                      rxActive;
    logic                      rxFrameError;

    modport master (
        output rxDv,
        output rxByte,
        output rxActive,
        output rxFrameError
    );

    modport slave (
        input rxDv,
        input rxByte,
        input rxActive,
        input rxFrameError
    );

endinterface

// File: rtl/uart_sync.sv
// N-flop synchronizer for asynchronous level inputs.
// Flops reset high so an idle UART line is not mistaken for a start bit.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            r_ff <= '1;
        else
            r_ff <= {r_ff[STAGES-2:0], i_d};
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Bit period is latched at start detection; stop-low frames enter BREAK.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        rxSerial,
    input  logic [31:0] clocksPerBit,
    uart_receiver_if.master rx
);

    logic                      w_sync;
    logic [31:0]               w_half;

    uart_state_t               r_state;
    logic [31:0]               r_cnt;
    logic [31:0]               r_n;
    logic [2:0]                r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_byte;
    logic                      r_dv;
    logic                      r_active;
    logic                      r_err;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rstN (rstN),
        .i_d  (rxSerial),
        .o_q  (w_sync)
    );

    assign w_half = r_n >> 1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_n      <= 32'(UART_MIN_CLOCKS_PER_BIT);
            r_idx    <= '0;
            r_shift  <= '0;
            r_byte   <= '0;
            r_dv     <= 1'b0;
            r_active <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_dv  <= 1'b0;
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_sync) begin
                        r_n      <= clamp_cpb(clocksPerBit);
                        r_cnt    <= '0;
                        r_active <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (r_cnt == w_half - 32'd1) begin
                        r_cnt <= '0;
                        if (!w_sync) begin
                            r_idx   <= '0;
                            r_state <= DATA;
                        end else begin
                            // Start bit vanished by mid-bit: a glitch.
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == r_n - 32'd1) begin
                        r_shift[r_idx] <= w_sync;
                        r_cnt          <= '0;
                        if (r_idx == 3'd7)
                            r_state <= STOP;
                        else
                            r_idx <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == r_n - 32'd1) begin
                        r_cnt    <= '0;
                        r_active <= 1'b0;
                        if (w_sync) begin
                            r_byte  <= r_shift;
                            r_dv    <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                BREAK: begin
                    if (w_sync)
                        r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rxDv         = r_dv;
    assign rx.rxByte       = r_byte;
    assign rx.rxActive     = r_active;
    assign rx.rxFrameError = r_err;

endmodule
